// File: rtl/ram_port_master.sv
// ram_port_master: byte-addressed load/store initiator for a 32-bit word RAM
// with byte enables and a registered (1-cycle) read port. Turns 1/2/4-byte
// requests into word accesses and assembles sign/zero-extended load results.
// Optional feature macro: RAM_PORT_MASTER_SPLIT_EN -- when defined, accesses
// that straddle a word boundary are split into two RAM accesses; otherwise
// they are rejected with an error response.
module ram_port_master #(
   parameter int RAM_ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [RAM_ADDR_WIDTH+1:0] req_addr,
   input  logic [1:0]                req_size,
   input  logic                      req_signed,
   input  logic [31:0]               req_wdata,
   output logic                      rsp_valid,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_error,
   output logic [3:0]                ram_we,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]               ram_din,
   input  logic [31:0]               ram_dout
);

`ifdef RAM_PORT_MASTER_SPLIT_EN
   localparam int LaneBytes = 8;
   typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, RESP} state_t;
`else
   localparam int LaneBytes = 4;
   typedef enum logic [2:0] {IDLE, WR_LO, RD_LO, RD_CAP, RESP} state_t;
`endif

   state_t                    r_state;
   state_t                    w_stateNext;
   logic [1:0]                r_off;
   logic [1:0]                r_size;
   logic                      r_signed;
   logic                      r_error;
   logic [31:0]               r_wdata;
   logic [RAM_ADDR_WIDTH-1:0] r_word;
   logic [RAM_ADDR_WIDTH-1:0] r_addrHold;
   logic [31:0]               r_dinHold;
   logic [31:0]               r_rdata;
`ifdef RAM_PORT_MASTER_SPLIT_EN
   logic                      r_span;
   logic [31:0]               r_lo;
`endif

   logic                      w_accept;
   logic                      w_reqSpan;
   logic                      w_reqError;
   logic [RAM_ADDR_WIDTH-1:0] w_reqWord;
   logic [3:0]                w_sizeMask;
   logic [LaneBytes-1:0]      w_laneMask;
   logic [8*LaneBytes-1:0]    w_laneData;
   logic [31:0]               w_loadVal;
   logic [31:0]               w_loadResult;

   assign w_accept  = req_valid && req_ready;
   assign w_reqWord = req_addr[RAM_ADDR_WIDTH+1:2];
   assign rsp_rdata = r_rdata;

   // Classify the incoming request: does it cross a word boundary, is it illegal
   always_comb begin
      w_reqSpan = 1'b0;
      case (req_size)
         2'd1:    w_reqSpan = (req_addr[1:0] == 2'd3);
         2'd2:    w_reqSpan = (req_addr[1:0] != 2'd0);
         default: w_reqSpan = 1'b0;
      endcase
`ifdef RAM_PORT_MASTER_SPLIT_EN
      w_reqError = (req_size == 2'd3) || (w_reqSpan && (&w_reqWord));
`else
      w_reqError = (req_size == 2'd3) || w_reqSpan;
`endif
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_stateNext;
   end

   // Next-state and state-decoded outputs; address/data hold their last value when idle
   always_comb begin
      w_stateNext = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_error   = 1'b0;
      ram_we      = 4'b0000;
      ram_addr    = r_addrHold;
      ram_din     = r_dinHold;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_reqError)     w_stateNext = RESP;
               else if (req_write) w_stateNext = WR_LO;
               else                w_stateNext = RD_LO;
            end
         end
         WR_LO: begin
            ram_we   = w_laneMask[3:0];
            ram_addr = r_word;
            ram_din  = w_laneData[31:0];
`ifdef RAM_PORT_MASTER_SPLIT_EN
            w_stateNext = r_span ? WR_HI : RESP;
`else
            w_stateNext = RESP;
`endif
         end
`ifdef RAM_PORT_MASTER_SPLIT_EN
         WR_HI: begin
            ram_we      = w_laneMask[7:4];
            ram_addr    = r_word + 1'b1;
            ram_din     = w_laneData[63:32];
            w_stateNext = RESP;
         end
         RD_HI: begin
            ram_addr    = r_word + 1'b1;
            w_stateNext = RD_CAP;
         end
`endif
         RD_LO: begin
            ram_addr = r_word;
`ifdef RAM_PORT_MASTER_SPLIT_EN
            w_stateNext = r_span ? RD_HI : RD_CAP;
`else
            w_stateNext = RD_CAP;
`endif
         end
         RD_CAP: w_stateNext = RESP;
         RESP: begin
            rsp_valid   = 1'b1;
            rsp_error   = r_error;
            w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Store lanes: byte mask and data shifted into place across one or two words
   always_comb begin
      case (r_size)
         2'd0:    w_sizeMask = 4'b0001;
         2'd1:    w_sizeMask = 4'b0011;
         default: w_sizeMask = 4'b1111;
      endcase
      w_laneMask       = '0;
      w_laneMask[3:0]  = w_sizeMask;
      w_laneMask       = w_laneMask << r_off;
      w_laneData       = '0;
      w_laneData[31:0] = r_wdata;
      w_laneData       = w_laneData << {r_off, 3'b000};
   end

   // Load result: right-align the addressed bytes, then sign or zero extend
   always_comb begin
`ifdef RAM_PORT_MASTER_SPLIT_EN
      w_loadVal = 32'({(r_span ? ram_dout : 32'd0), (r_span ? r_lo : ram_dout)} >> {r_off, 3'b000});
`else
      w_loadVal = ram_dout >> {r_off, 3'b000};
`endif
      case (r_size)
         2'd0:    w_loadResult = r_signed ? {{24{w_loadVal[7]}}, w_loadVal[7:0]}
                                          : {24'd0, w_loadVal[7:0]};
         2'd1:    w_loadResult = r_signed ? {{16{w_loadVal[15]}}, w_loadVal[15:0]}
                                          : {16'd0, w_loadVal[15:0]};
         default: w_loadResult = w_loadVal;
      endcase
   end

   // Request latch, RAM output hold registers, low-word capture and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_off      <= 2'd0;
         r_size     <= 2'd0;
         r_signed   <= 1'b0;
         r_error    <= 1'b0;
         r_wdata    <= 32'd0;
         r_word     <= '0;
         r_addrHold <= '0;
         r_dinHold  <= 32'd0;
         r_rdata    <= 32'd0;
`ifdef RAM_PORT_MASTER_SPLIT_EN
         r_span     <= 1'b0;
         r_lo       <= 32'd0;
`endif
      end else begin
         r_addrHold <= ram_addr;
         r_dinHold  <= ram_din;
         if (w_accept) begin
            r_off    <= req_addr[1:0];
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            r_word   <= w_reqWord;
            r_error  <= w_reqError;
            r_rdata  <= 32'd0;
`ifdef RAM_PORT_MASTER_SPLIT_EN
            r_span   <= w_reqSpan;
`endif
         end
`ifdef RAM_PORT_MASTER_SPLIT_EN
         if (r_state == RD_HI) r_lo <= ram_dout;
`endif
         if (r_state == RD_CAP) r_rdata <= w_loadResult;
      end
   end

endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: directed bench for ram_port_master with a byte-level
// reference memory model and a registered-read word RAM behind port A.
// Follows RAM_PORT_MASTER_SPLIT_EN the same way the design does.
module tb_ram_port_master;

   localparam int AW    = 4;
   localparam int AddrW = AW + 2;
   localparam int Words = 1 << AW;
`ifdef RAM_PORT_MASTER_SPLIT_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_write = 1'b0;
   logic             req_signed = 1'b0;
   logic [AddrW-1:0] req_addr = '0;
   logic [1:0]       req_size = 2'd0;
   logic [31:0]      req_wdata = 32'd0;
   logic             req_ready, rsp_valid, rsp_error;
   logic [31:0]      rsp_rdata, ram_din, ram_dout;
   logic [3:0]       ram_we;
   logic [AW-1:0]    ram_addr;

   ram_port_master #(.RAM_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Word RAM with byte enables and one cycle of read latency, cleared on the first edge
   logic [31:0] ramMem [Words];
   bit          memInit = 1'b0;
   always @(posedge clk) begin
      if (!memInit) begin
         for (int i = 0; i < Words; i++) ramMem[i] <= 32'd0;
         memInit <= 1'b1;
      end else begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ramMem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
      ram_dout <= ramMem[ram_addr];
   end

   // Reference model state: byte-addressed memory and per-transaction expectations
   logic [7:0]    refMem [4*Words];
   int            assertCount = 0;
   int            failCount = 0;
   bit            active = 1'b0;
   int            cycleIdx = 0;
   int            expLat = 0;
   bit            expWrite, expSpan, expError;
   logic [31:0]   expRdata, expDin1, expDin2;
   logic [3:0]    expWe1, expWe2;
   logic [AW-1:0] expAddr1, expAddr2;
   int            lastLat = 0;
   logic [31:0]   lastRdata = 32'd0;
   logic          lastError = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] laneBits(input logic [3:0] we);
      logic [31:0] m;
      m = 32'd0;
      for (int b = 0; b < 4; b++) if (we[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [31:0] refWord(input int w);
      return {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
   endfunction

   // Per-cycle comparison of the DUT against the current transaction's expectations
   always @(negedge clk) begin : compare
      logic [3:0] weNow;
      if (active) begin
         cycleIdx = cycleIdx + 1;
         checkOutput("req_ready busy", 32'(req_ready), 32'd0);
         checkOutput("rsp_valid timing", 32'(rsp_valid), 32'(cycleIdx == expLat));
         if (rsp_valid) begin
            lastLat   = cycleIdx;
            lastRdata = rsp_rdata;
            lastError = rsp_error;
            checkOutput("rsp_error", 32'(rsp_error), 32'(expError));
            checkOutput("rsp_rdata", rsp_rdata, expRdata);
         end
         weNow = 4'b0000;
         if (expWrite && !expError && cycleIdx == 1) weNow = expWe1;
         if (expWrite && !expError && expSpan && cycleIdx == 2) weNow = expWe2;
         checkOutput("ram_we", 32'(ram_we), 32'(weNow));
         if (weNow != 4'b0000) begin
            checkOutput("ram_addr", 32'(ram_addr), 32'((cycleIdx == 1) ? expAddr1 : expAddr2));
            checkOutput("ram_din", ram_din & laneBits(weNow),
                        ((cycleIdx == 1) ? expDin1 : expDin2) & laneBits(weNow));
         end
         if (cycleIdx >= expLat) active = 1'b0;
      end else if (!rst) begin
         checkOutput("rsp_valid idle", 32'(rsp_valid), 32'd0);
      end
   end

   task automatic waitReady();
      int guard = 0;
      @(negedge clk); #1;
      while (!req_ready && guard < 20) begin
         @(negedge clk); #1;
         guard++;
      end
      if (!req_ready) checkOutput("req_ready wait timeout", 32'(req_ready), 32'd1);
   endtask

   // Issue one request, predict its outcome from byte-level rules, wait for completion
   task automatic applyStimulus(input logic wr, input int addr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] wdata);
      int n, off, word, lane, guard;
      bit span, err;
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off  = addr % 4;
      word = addr / 4;
      span = (off + n > 4);
      err  = (size == 2'd3) || (span && (!SplitEn || word == Words - 1));
      expWe1 = 4'b0; expWe2 = 4'b0; expDin1 = 32'd0; expDin2 = 32'd0; expRdata = 32'd0;
      if (!err && wr) begin
         for (int i = 0; i < n; i++) begin
            lane = off + i;
            if (lane < 4) begin
               expWe1[lane] = 1'b1;
               expDin1[8*lane +: 8] = wdata[8*i +: 8];
            end else begin
               expWe2[lane-4] = 1'b1;
               expDin2[8*(lane-4) +: 8] = wdata[8*i +: 8];
            end
            refMem[addr+i] = wdata[8*i +: 8];
         end
      end
      if (!err && !wr) begin
         for (int i = 0; i < n; i++) expRdata[8*i +: 8] = refMem[addr+i];
         if (sgn && n < 4 && expRdata[8*n-1])
            for (int i = n; i < 4; i++) expRdata[8*i +: 8] = 8'hFF;
      end
      expWrite = wr; expSpan = span; expError = err;
      expLat   = err ? 1 : (wr ? (span ? 3 : 2) : (span ? 4 : 3));
      expAddr1 = AW'(word);
      expAddr2 = AW'(word + 1);
      waitReady();
      req_valid = 1'b1; req_write = wr; req_addr = AddrW'(addr);
      req_size = size; req_signed = sgn; req_wdata = wdata;
      cycleIdx = 0; lastLat = 0; active = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      guard = 0;
      while (active && guard < 20) begin
         @(negedge clk); #2;
         guard++;
      end
      if (active) begin
         checkOutput("response timeout", 32'(active), 32'd0);
         active = 1'b0;
      end
      if (!err && wr) begin
         checkOutput("mem word lo", ramMem[word], refWord(word));
         if (span) checkOutput("mem word hi", ramMem[word+1], refWord(word + 1));
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
      checkOutput({tag, " rsp_error"}, 32'(rsp_error), 32'd0);
      checkOutput({tag, " ram_we"}, 32'(ram_we), 32'd0);
      checkOutput({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
      checkOutput({tag, " ram_din"}, ram_din, 32'd0);
   endtask

   // Start a store and assert reset in cycle cyc after the accept edge
   task automatic resetDuring(input int addr, input logic [1:0] size, input logic [31:0] wdata,
                              input int cyc);
      int n, off, word;
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off  = addr % 4;
      word = addr / 4;
      waitReady();
      req_valid = 1'b1; req_write = 1'b1; req_addr = AddrW'(addr);
      req_size = size; req_signed = 1'b0; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c < cyc; c++) begin
         @(posedge clk); #1;
      end
      #1 rst = 1'b1;
      #1 checkResetValues("mid-reset");
      if (cyc == 2)
         for (int i = 0; i < n; i++)
            if (off + i < 4) refMem[addr+i] = wdata[8*i +: 8];
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1 checkOutput("ready after reset", 32'(req_ready), 32'd1);
      checkOutput("reset mem lo", ramMem[word], refWord(word));
      checkOutput("reset mem hi", ramMem[word+1], refWord(word + 1));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4*Words; i++) refMem[i] = 8'h00;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 checkResetValues("reset");
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1'b1, 'h04, 2'd2, 1'b0, 32'hDEADBEEF);
      checkOutput("word store latency", 32'(lastLat), 32'd2);
      checkOutput("word store error", 32'(lastError), 32'd0);
      checkOutput("word store mem", ramMem[1], 32'hDEADBEEF);

      applyStimulus(1'b1, 'h00, 2'd2, 1'b0, 32'h00800000);
      applyStimulus(1'b0, 'h02, 2'd0, 1'b1, 32'd0);
      checkOutput("signed byte load", lastRdata, 32'hFFFFFF80);
      checkOutput("signed byte latency", 32'(lastLat), 32'd3);
      applyStimulus(1'b0, 'h02, 2'd0, 1'b0, 32'd0);
      checkOutput("unsigned byte load", lastRdata, 32'h00000080);

      applyStimulus(1'b1, 'h04, 2'd2, 1'b0, 32'h44332211);
      applyStimulus(1'b1, 'h08, 2'd2, 1'b0, 32'h88776655);
      applyStimulus(1'b0, 'h06, 2'd2, 1'b0, 32'd0);
`ifdef RAM_PORT_MASTER_SPLIT_EN
      checkOutput("spanning word load", lastRdata, 32'h66554433);
      checkOutput("spanning load latency", 32'(lastLat), 32'd4);
`else
      checkOutput("spanning load error", 32'(lastError), 32'd1);
      checkOutput("spanning load latency", 32'(lastLat), 32'd1);
`endif
      applyStimulus(1'b0, 4*Words - 3, 2'd2, 1'b0, 32'd0);
      checkOutput("last word span error", 32'(lastError), 32'd1);

      applyStimulus(1'b0, 'h10, 2'd3, 1'b0, 32'd0);
      checkOutput("size3 error", 32'(lastError), 32'd1);
      checkOutput("size3 rdata", lastRdata, 32'd0);
      checkOutput("size3 latency", 32'(lastLat), 32'd1);
      applyStimulus(1'b1, 'h10, 2'd3, 1'b0, 32'hFFFFFFFF);

      applyStimulus(1'b1, 'h01, 2'd2, 1'b0, 32'h11223344);
`ifndef RAM_PORT_MASTER_SPLIT_EN
      checkOutput("unaligned store error", 32'(lastError), 32'd1);
`endif
      applyStimulus(1'b1, 'h03, 2'd1, 1'b0, 32'h0000BEEF);
      applyStimulus(1'b0, 'h03, 2'd1, 1'b0, 32'd0);
`ifdef RAM_PORT_MASTER_SPLIT_EN
      checkOutput("spanning half load", lastRdata, 32'h0000BEEF);
      checkOutput("spanning half latency", 32'(lastLat), 32'd4);
      checkOutput("half store lo byte", 32'(ramMem[0][31:24]), 32'hEF);
      checkOutput("half store hi byte", 32'(ramMem[1][7:0]), 32'hBE);
`endif
      applyStimulus(1'b0, 'h03, 2'd1, 1'b1, 32'd0);

      applyStimulus(1'b1, 'h21, 2'd0, 1'b0, 32'hFFFFFFA5);
      applyStimulus(1'b0, 'h21, 2'd0, 1'b0, 32'd0);
      checkOutput("unsigned byte A5", lastRdata, 32'h000000A5);
      applyStimulus(1'b0, 'h20, 2'd1, 1'b1, 32'd0);
      applyStimulus(1'b0, 'h20, 2'd2, 1'b0, 32'd0);

      applyStimulus(1'b1, 4*Words - 4, 2'd2, 1'b0, 32'hA1B2C3D4);
      applyStimulus(1'b1, 4*Words - 2, 2'd1, 1'b0, 32'h00009ABC);
      applyStimulus(1'b0, 4*Words - 2, 2'd1, 1'b1, 32'd0);
      checkOutput("last word signed half", lastRdata, 32'hFFFF9ABC);
      applyStimulus(1'b1, 4*Words - 1, 2'd1, 1'b0, 32'h00001234);
      checkOutput("last word half span error", 32'(lastError), 32'd1);
      applyStimulus(1'b0, 4*Words - 4, 2'd2, 1'b0, 32'd0);

`ifdef RAM_PORT_MASTER_SPLIT_EN
      resetDuring('h0F, 2'd1, 32'h00001234, 2);
      checkOutput("partial store lo", ramMem[3], 32'h34000000);
      checkOutput("partial store hi", ramMem[4], 32'h00000000);
`endif
      resetDuring('h28, 2'd2, 32'hCAFEF00D, 1);
      applyStimulus(1'b0, 'h04, 2'd2, 1'b0, 32'd0);
      applyStimulus(1'b0, 'h0E, 2'd1, 1'b0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
